// File: rtl/led_frame_scheduler.sv
// Streams a register-based pixel store to a WS2812 driver once per refresh tick,
// then holds the strip latch gap; counts completed frames and refresh overruns.
module led_frame_scheduler #(
    parameter int NUM_LEDS     = 72,
    parameter int FRAME_CYCLES = 1_666_667,
    parameter int LATCH_CYCLES = 8_000
) (
    input  logic        clk_100mhz,
    input  logic        rst_n,
    input  logic        pix_valid,
    input  logic [6:0]  pix_index,
    input  logic [23:0] pix_rgb,
    output logic        drv_valid,
    output logic [23:0] drv_data,
    output logic        drv_last,
    input  logic        drv_ready,
    output logic        frame_start,
    output logic        busy,
    output logic [15:0] frame_count,
    output logic [7:0]  overrun_count,
    output logic [1:0]  fsm_state
);

    localparam int IW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int TW = (FRAME_CYCLES > 2) ? $clog2(FRAME_CYCLES) : 1;
    localparam int LW = (LATCH_CYCLES > 2) ? $clog2(LATCH_CYCLES) : 1;
    localparam logic [6:0]    LAST_IDX  = 7'(NUM_LEDS - 1);
    localparam logic [7:0]    NUM_LEDS8 = 8'(NUM_LEDS);
    localparam logic [TW-1:0] TICK_AT   = TW'(FRAME_CYCLES - 1);
    localparam logic [LW-1:0] LATCH_END = LW'(LATCH_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        LATCH = 2'd2
    } state_t;

    state_t        state, state_d;
    logic          pending, pending_d;
    logic [6:0]    rd_idx, rd_idx_d;
    logic [TW-1:0] timer;
    logic [LW-1:0] latch_cnt, latch_d;
    logic          valid_d;
    logic [23:0]   data_d;
    logic          fstart_d;
    logic [15:0]   fcount_d;
    logic [7:0]    ovr_d;
    logic          start_frame;
    logic          tick;
    logic          wr_en;
    logic [IW-1:0] next_idx;
    logic [23:0]   store [NUM_LEDS];

    assign tick      = (timer == TICK_AT);
    assign wr_en     = pix_valid && ({1'b0, pix_index} < NUM_LEDS8);
    assign next_idx  = rd_idx[IW-1:0] + IW'(1);
    assign busy      = (state != IDLE);
    assign drv_last  = drv_valid && (rd_idx == LAST_IDX);
    assign fsm_state = state;

    // Handshake: a beat transfers on any cycle with drv_valid && drv_ready; while
    // drv_valid is high and drv_ready low, drv_data/drv_last do not change.
    always_comb begin
        state_d     = state;
        pending_d   = pending;
        rd_idx_d    = rd_idx;
        latch_d     = latch_cnt;
        valid_d     = drv_valid;
        data_d      = drv_data;
        fstart_d    = 1'b0;
        fcount_d    = frame_count;
        ovr_d       = overrun_count;
        start_frame = 1'b0;

        // Only one frame can be queued; later ticks are merely counted.
        if (tick && (state != IDLE)) begin
            pending_d = 1'b1;
            if (overrun_count != 8'hFF) begin
                ovr_d = overrun_count + 8'd1;
            end
        end

        case (state)
            IDLE: begin
                if (tick || pending) begin
                    start_frame = 1'b1;
                end
            end
            SEND: begin
                if (drv_valid && drv_ready) begin
                    if (rd_idx == LAST_IDX) begin
                        valid_d  = 1'b0;
                        fcount_d = frame_count + 16'd1;
                        latch_d  = '0;
                        state_d  = LATCH;
                    end else begin
                        rd_idx_d = rd_idx + 7'd1;
                        data_d   = store[next_idx];
                    end
                end
            end
            LATCH: begin
                if (latch_cnt == LATCH_END) begin
                    if (pending_d) begin
                        start_frame = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    latch_d = latch_cnt + LW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Store reads are asynchronous, so a same-cycle write is not yet visible here.
        if (start_frame) begin
            state_d   = SEND;
            data_d    = store[0];
            rd_idx_d  = '0;
            valid_d   = 1'b1;
            fstart_d  = 1'b1;
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk_100mhz) begin
        if (!rst_n) begin
            state         <= IDLE;
            pending       <= 1'b0;
            rd_idx        <= '0;
            timer         <= '0;
            latch_cnt     <= '0;
            drv_valid     <= 1'b0;
            drv_data      <= '0;
            frame_start   <= 1'b0;
            frame_count   <= '0;
            overrun_count <= '0;
            for (int i = 0; i < NUM_LEDS; i++) begin
                store[i] <= '0;
            end
        end else begin
            state         <= state_d;
            pending       <= pending_d;
            rd_idx        <= rd_idx_d;
            timer         <= tick ? '0 : timer + TW'(1);
            latch_cnt     <= latch_d;
            drv_valid     <= valid_d;
            drv_data      <= data_d;
            frame_start   <= fstart_d;
            frame_count   <= fcount_d;
            overrun_count <= ovr_d;
            if (wr_en) begin
                store[pix_index[IW-1:0]] <= pix_rgb;
            end
        end
    end

endmodule
